// File: rtl/pipe_stage4.sv
// pipe_stage4 -- consumer of the interval-check stage.
//
// Owns the per-lane consecutive-in-interval counters. They feed back to the
// check stage, which reads them as interval_cnt_i. Each accepted token
// updates the counters. A lane raises a sticky exit flag once its counter
// reaches PATIENCE. The batch completes when every masked lane has exited,
// or when MAX_LAYERS tokens have been accepted.
//
// Optional feature: define PIPE_STAGE4_EXIT_LAYER_EN to add exit_layer_o.
// That output holds, per lane, the layer count at which the lane first exited.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   start_i                 one-cycle pulse: clear state, latch lane_mask_i, RUN
//   lane_mask_i             active lanes (sampled on start_i)
//   in_valid_i/in_ready_o   token handshake from stage 3
//   out_of_mode_interval_i  per-lane out-of-interval flag of the token
//   interval_cnt_o          per-lane counters, LANES x PARA, lane 0 in LSBs
//   out_valid_o/out_ready_i result handshake (single output register)
//   exit_o                  sticky per-lane exit flags
//   layer_cnt_o             tokens accepted this batch
//   exit_layer_o            (optional) per-lane exit layer, 0 if not exited
//   done_o                  batch complete

module pipe_stage4_lane #(
    parameter int PARA     = 16,
    parameter int PATIENCE = 4,
    parameter int LW       = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr,
    input  logic            acc,
    input  logic            mask,
    input  logic            oomi,
`ifdef PIPE_STAGE4_EXIT_LAYER_EN
    input  logic [LW-1:0]   layer_new,
    output logic [LW-1:0]   exit_layer,
`endif
    output logic [PARA-1:0] cnt,
    output logic            exit_q,
    output logic            exit_nxt
);
    logic [PARA-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        // Exited or masked-off lanes freeze their counters.
        if (mask && !exit_q) begin
            if (oomi)
                cnt_nxt = '0;
            else if (cnt != {PARA{1'b1}})
                cnt_nxt = cnt + PARA'(1);
        end
    end

    assign exit_nxt = exit_q | (mask && (cnt_nxt >= PARA'(PATIENCE)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt    <= '0;
            exit_q <= 1'b0;
        end else if (clr) begin
            cnt    <= '0;
            exit_q <= 1'b0;
        end else if (acc) begin
            cnt    <= cnt_nxt;
            exit_q <= exit_nxt;
        end
    end

`ifdef PIPE_STAGE4_EXIT_LAYER_EN
    // Capture the layer count only on the accept that first sets the flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            exit_layer <= '0;
        else if (clr)
            exit_layer <= '0;
        else if (acc && exit_nxt && !exit_q)
            exit_layer <= layer_new;
    end
`endif
endmodule

module pipe_stage4 #(
    parameter int LANES      = 4,
    parameter int PARA       = 16,
    parameter int PATIENCE   = 4,
    parameter int MAX_LAYERS = 32,
    parameter int LW         = $clog2(MAX_LAYERS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [LANES-1:0]      lane_mask_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [LANES-1:0]      out_of_mode_interval_i,
    output logic [LANES*PARA-1:0] interval_cnt_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [LANES-1:0]      exit_o,
    output logic [LW-1:0]         layer_cnt_o,
`ifdef PIPE_STAGE4_EXIT_LAYER_EN
    output logic [LANES*LW-1:0]   exit_layer_o,
`endif
    output logic                  done_o
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                      state;
    logic [LANES-1:0]            mask_q;
    logic [LANES-1:0]            exit_nxt;
    logic [LANES-1:0][PARA-1:0]  cnt;
    logic [LW-1:0]               layer_new;
    logic                        acc;
    logic                        fin;

    // A token arriving together with start_i is dropped: start wins.
    assign in_ready_o = (state == S_RUN) && (!out_valid_o || out_ready_i);
    assign acc        = in_valid_i && in_ready_o && !start_i;
    assign layer_new  = layer_cnt_o + LW'(1);
    // Unmasked lanes count as exited, so an empty mask finishes on the first accept.
    assign fin        = (&(exit_nxt | ~mask_q)) || (layer_new == LW'(MAX_LAYERS));

`ifdef PIPE_STAGE4_EXIT_LAYER_EN
    logic [LANES-1:0][LW-1:0] exit_layer;
    assign exit_layer_o = exit_layer;
`endif
    assign interval_cnt_o = cnt;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            pipe_stage4_lane #(.PARA(PARA), .PATIENCE(PATIENCE), .LW(LW)) u_lane (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .clr       (start_i),
                .acc       (acc),
                .mask      (mask_q[g]),
                .oomi      (out_of_mode_interval_i[g]),
`ifdef PIPE_STAGE4_EXIT_LAYER_EN
                .layer_new (layer_new),
                .exit_layer(exit_layer[g]),
`endif
                .cnt       (cnt[g]),
                .exit_q    (exit_o[g]),
                .exit_nxt  (exit_nxt[g])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            mask_q      <= '0;
            layer_cnt_o <= '0;
            out_valid_o <= 1'b0;
            done_o      <= 1'b0;
        end else if (start_i) begin
            state       <= S_RUN;
            mask_q      <= lane_mask_i;
            layer_cnt_o <= '0;
            out_valid_o <= 1'b0;
            done_o      <= 1'b0;
        end else if (acc) begin
            layer_cnt_o <= layer_new;
            out_valid_o <= 1'b1;
            if (fin) begin
                state  <= S_DONE;
                done_o <= 1'b1;
            end
        end else if (out_ready_i) begin
            // The final result still drains normally once in DONE.
            out_valid_o <= 1'b0;
        end
    end
endmodule

// File: doc/pipe_stage4.md
Name: pipe_stage4

Overview:
- Downstream consumer of the interval-check stage (pipe_stage3).
- Owns the per-lane consecutive-in-interval counters; their values feed back to the check stage's interval_cnt_i.
- Each accepted token carries one out_of_mode_interval vector (one per layer evaluation). The block updates the counters, raises sticky per-lane early-exit flags at PATIENCE, and signals batch completion through valid/ready handshakes.

Parameters:
- LANES, 4, number of parallel score lanes.
- PARA, 16, counter width in bits.
- PATIENCE, 4, consecutive in-interval layers required for a lane to exit (1 ≤ PATIENCE ≤ 2^PARA-1).
- MAX_LAYERS, 32, layer-count limit forcing batch completion.
- LW, $clog2(MAX_LAYERS+1), layer counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  one-cycle pulse; clears state, begins a batch.
- lane_mask_i  in  LANES  active lanes; sampled on start_i.
- in_valid_i  in  1  token valid from stage 3.
- in_ready_o  out  1  token accept.
- out_of_mode_interval_i  in  LANES  per-lane out-of-interval result.
- interval_cnt_o  out  LANES*PARA  current counters (feedback to stage 3).
- out_valid_o  out  1  update result valid.
- out_ready_i  in  1  downstream accept.
- exit_o  out  LANES  sticky per-lane exit flags, registered with out_valid_o.
- layer_cnt_o  out  LW  layers accepted this batch.
- done_o  out  1  batch complete (state DONE).

Behaviour:
- Reset values: counters 0, exit_o 0, layer_cnt_o 0, out_valid_o 0, done_o 0, state IDLE, lane mask 0.
- FSM states:
  - IDLE: in_ready_o=0.
  - RUN
  - DONE: in_ready_o=0, done_o=1.
- start_i in any state:
  - clears counters, exit flags, layer_cnt and out_valid_o (flushes the pending result);
  - latches lane_mask_i;
  - next state RUN.
  - start_i has priority over a same-cycle accept; that token is dropped.
- RUN: in_ready_o = !out_valid_o || out_ready_i. This is a single output register; a full-throughput handshake completes one token per cycle.
- Accept = in_valid_i && in_ready_o. On accept, per lane i:
  - if !mask[i] or exit[i]: counter held;
  - else if out_of_mode_interval_i[i]: counter ← 0;
  - else counter ← counter+1, saturating at 2^PARA-1.
  - exit[i] ← exit[i] | (mask[i] && new counter ≥ PATIENCE).
  - layer_cnt ← layer_cnt+1.
  - out_valid_o ← 1.
- Latency: accept → out_valid_o, updated exit_o and interval_cnt_o in the next cycle (1 cycle).
- out_valid_o clears on out_ready_i with no new accept.
- RUN → DONE on the accept where:
  - every masked lane is exited after the update; or
  - the new layer_cnt = MAX_LAYERS.
- The final result still presents out_valid_o and drains normally in DONE.
- lane_mask_i = 0 on start: enter RUN; the first accept moves the FSM to DONE (vacuously all exited).
- in_valid_i while not ready: token is held by the upstream (standard valid stability); no state change.
- Asynchronous reset mid-batch returns every register to its reset value immediately.

Optional Feature:
- Macro PIPE_STAGE4_EXIT_LAYER_EN.
- When defined:
  - adds output exit_layer_o (LANES*LW) with per-lane layer_cnt value (post-increment) captured on the accept that first sets exit[i];
  - unexited lanes read 0;
  - cleared on reset and start_i.
- When undefined: the port and registers are absent; all other behaviour is identical.

Test Plan:
- Reset then start_i with mask=4'b1111, PATIENCE=4; four accepts with out_of_mode_interval_i=0 → counters 1,2,3,4; exit_o=4'b1111 after the 4th; done_o=1; layer_cnt_o=4; exit_layer_o lanes = 4 (macro on).
- Lane 2 pattern 0,0,1,0,0,0,0 → lane-2 counter 1,2,0,1,2,3,4; exit_o[2] set on the 7th accept only.
- mask=4'b0011; lanes 2–3 always in-interval → their counters stay 0, exit_o[3:2]=0; done_o once lanes 0–1 exit.
- Alternate out_of_mode_interval_i=4'b1111 and 0 for MAX_LAYERS=32 accepts → no exits; done_o after the 32nd accept; layer_cnt_o=32; in_ready_o=0 afterwards.
- Hold out_ready_i=0 with out_valid_o=1 → in_ready_o=0, counters frozen; release → one-per-cycle throughput resumes.
- start_i coincident with an accepted token, and rst_i asserted mid-batch → counters and exit_o zero, out_valid_o=0; the token is not counted.
